rbus_inject_sched: RTL and testbench

- Injection scheduler in front of one rbus ring stop.
- Shares the stop's two local injection ports (In0/A, In1/B) among NREQ local agents (L2 slices, IO bridge).
- Round-robin grants, gated by the stop's rbus_rdyIn and by an outstanding-transaction credit pool.
- Per-requester aging forces a granted slot for any agent starved by ring transit traffic.

---
 rtl/rbus_sched_pkg.sv | 31 +++
 rtl/rbus_inject_sched_rr_pick2.sv | 75 +++++++
 rtl/rbus_inject_sched.sv | 167 ++++++++++++++++
 tb/tb_rbus_inject_sched.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rbus_sched_pkg.sv
// ============================================================================
// rbus_sched_pkg : shared types, widths and helpers for the rbus injection
//                  scheduler.  Rev 1.0
// ============================================================================
`default_nettype none

package rbus_sched_pkg;

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      STARVE = 1'b1
   } state_t;

   localparam int WAIT_W   = 4;
   localparam int CRED_W   = 4;
   localparam int MAX_NREQ = 8;

   // Returns a one-hot vector sized for the largest supported NREQ; callers
   // size-cast it down to their own requester count.
   function automatic logic [MAX_NREQ-1:0] onehot(input int idx, input int nreq);
      logic [MAX_NREQ-1:0] v;
      v = '0;
      for (int i = 0; i < MAX_NREQ; i++) begin
         if (i == idx && i < nreq) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rbus_inject_sched_rr_pick2.sv
// ============================================================================
// rr_pick2 : combinational round-robin picker producing a first and (with
//            RBUS_INJ_DUAL_EN) a second requester index.  Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick2
   import rbus_sched_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             force_en,
   input  logic [IDX_W-1:0] force_idx,
   output logic             first_vld,
   output logic [IDX_W-1:0] first_idx
`ifdef RBUS_INJ_DUAL_EN
   ,
   output logic             second_vld,
   output logic [IDX_W-1:0] second_idx
`endif
);

   // Scan distance from ptr (with wrap); the smallest distance wins.
   always_comb begin
      int d;
      int best;
      d         = 0;
      best      = NREQ;
      first_vld = 1'b0;
      first_idx = '0;
      if (force_en) begin
         first_vld = 1'b1;
         first_idx = force_idx;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            d = i - int'(ptr);
            if (d < 0) d = d + NREQ;
            if (req[i] && d < best) begin
               best      = d;
               first_vld = 1'b1;
               first_idx = IDX_W'(i);
            end
         end
      end
   end

`ifdef RBUS_INJ_DUAL_EN
   // Second pick continues the scan just after the first, excluding it.
   always_comb begin
      int d;
      int best;
      d          = 0;
      best       = NREQ;
      second_vld = 1'b0;
      second_idx = '0;
      if (first_vld) begin
         for (int i = 0; i < NREQ; i++) begin
            d = i - int'(first_idx);
            if (d < 0) d = d + NREQ;
            if (req[i] && d != 0 && d < best) begin
               best       = d;
               second_vld = 1'b1;
               second_idx = IDX_W'(i);
            end
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: rtl/rbus_inject_sched.sv
// ============================================================================
// rbus_inject_sched : round-robin injection scheduler for one rbus ring stop,
//                     with credit gating and starvation aging.
//                     Optional dual-port injection: `define RBUS_INJ_DUAL_EN.
//                     Rev 1.0
// ============================================================================
`default_nettype none

module rbus_inject_sched
   import rbus_sched_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int STARVE_MAX = 15,
   parameter int MAX_OUTST  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   output logic [NREQ-1:0]   gntA,
   output logic [NREQ-1:0]   gntB,
   output logic              rbus_rdyOutA,
   output logic              rbus_rdyOutB,
   input  logic              rbus_rdyIn,
   input  logic              rsp_done,
   output logic [CRED_W-1:0] credits,
   output logic              starve,
   output logic              credit_err
);

   localparam int                IDX_W      = $clog2(NREQ);
   localparam logic [WAIT_W-1:0] C_WAIT_MAX = WAIT_W'(STARVE_MAX);
   localparam logic [CRED_W-1:0] C_CRED_MAX = CRED_W'(MAX_OUTST);

   state_t             r_state;
   logic [IDX_W-1:0]   r_ptr;
   logic [CRED_W-1:0]  r_credits;
   logic [WAIT_W-1:0]  r_wait [NREQ];
   logic               r_credit_err;

   logic               w_force_hit;
   logic               w_force_en;
   logic [IDX_W-1:0]   w_force_idx;
   logic               w_first_vld;
   logic [IDX_W-1:0]   w_first_idx;
   logic               w_accA;
   logic               w_accB;
   logic               w_ret;
   logic               w_ret_err;
   logic [IDX_W-1:0]   w_ptr_nxt;
   logic [CRED_W-1:0]  w_credits_nxt;
   logic [WAIT_W-1:0]  w_wait_nxt [NREQ];
   logic               w_any_max_nxt;

   function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] idx);
      return (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
   endfunction

   // Lowest-index aged agent that is still requesting; a dropped request
   // must never be granted even if its counter has not cleared yet.
   always_comb begin
      w_force_hit = 1'b0;
      w_force_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (r_wait[i] == C_WAIT_MAX && req[i]) begin
            w_force_hit = 1'b1;
            w_force_idx = IDX_W'(i);
         end
      end
      w_force_en = (r_state == STARVE) && w_force_hit;
   end

`ifdef RBUS_INJ_DUAL_EN
   logic               w_second_vld;
   logic [IDX_W-1:0]   w_second_idx;

   rr_pick2 #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
      .req        (req),
      .ptr        (r_ptr),
      .force_en   (w_force_en),
      .force_idx  (w_force_idx),
      .first_vld  (w_first_vld),
      .first_idx  (w_first_idx),
      .second_vld (w_second_vld),
      .second_idx (w_second_idx)
   );

   assign gntB = (w_second_vld && r_credits >= CRED_W'(2))
                 ? NREQ'(onehot(int'(w_second_idx), NREQ)) : '0;
`else
   rr_pick2 #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
      .req        (req),
      .ptr        (r_ptr),
      .force_en   (w_force_en),
      .force_idx  (w_force_idx),
      .first_vld  (w_first_vld),
      .first_idx  (w_first_idx)
   );

   assign gntB = '0;
`endif

   assign gntA = (w_first_vld && r_credits != '0)
                 ? NREQ'(onehot(int'(w_first_idx), NREQ)) : '0;

   assign rbus_rdyOutA = |gntA;
   assign rbus_rdyOutB = |gntB;
   assign w_accA       = rbus_rdyOutA & rbus_rdyIn;
   assign w_accB       = rbus_rdyOutB & rbus_rdyIn;
   assign w_ret        = rsp_done && (r_credits != C_CRED_MAX);
   assign w_ret_err    = rsp_done && (r_credits == C_CRED_MAX);

   always_comb begin
      w_ptr_nxt = r_ptr;
`ifdef RBUS_INJ_DUAL_EN
      if (w_accB)      w_ptr_nxt = ptr_inc(w_second_idx);
      else if (w_accA) w_ptr_nxt = ptr_inc(w_first_idx);
`else
      if (w_accA)      w_ptr_nxt = ptr_inc(w_first_idx);
`endif
   end

   assign w_credits_nxt = r_credits
                        - {{(CRED_W-1){1'b0}}, w_accA}
                        - {{(CRED_W-1){1'b0}}, w_accB}
                        + {{(CRED_W-1){1'b0}}, w_ret};

   always_comb begin
      w_any_max_nxt = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!req[i] || (gntA[i] && w_accA) || (gntB[i] && w_accB))
            w_wait_nxt[i] = '0;
         else if (r_wait[i] == C_WAIT_MAX)
            w_wait_nxt[i] = r_wait[i];
         else
            w_wait_nxt[i] = r_wait[i] + 1'b1;
         if (w_wait_nxt[i] == C_WAIT_MAX) w_any_max_nxt = 1'b1;
      end
   end

   // State tracks whether any counter will sit at the limit after this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= RUN;
         r_ptr        <= '0;
         r_credits    <= C_CRED_MAX;
         r_credit_err <= 1'b0;
         for (int i = 0; i < NREQ; i++) r_wait[i] <= '0;
      end else begin
         r_ptr     <= w_ptr_nxt;
         r_credits <= w_credits_nxt;
         for (int i = 0; i < NREQ; i++) r_wait[i] <= w_wait_nxt[i];
         if (w_ret_err) r_credit_err <= 1'b1;
         case (r_state)
            RUN:     if (w_any_max_nxt)  r_state <= STARVE;
            STARVE:  if (!w_any_max_nxt) r_state <= RUN;
            default: r_state <= RUN;
         endcase
      end
   end

   assign credits    = r_credits;
   assign starve     = (r_state == STARVE);
   assign credit_err = r_credit_err;

endmodule

`default_nettype wire

// File: tb/tb_rbus_inject_sched.sv
// ============================================================================
// tb_rbus_inject_sched : directed self-checking bench for rbus_inject_sched,
//                        expectations follow RBUS_INJ_DUAL_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_rbus_inject_sched;

`ifdef RBUS_INJ_DUAL_EN
   localparam bit DUAL = 1'b1;
`else
   localparam bit DUAL = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gntA;
   logic [3:0] gntB;
   logic       rbus_rdyOutA;
   logic       rbus_rdyOutB;
   logic       rbus_rdyIn;
   logic       rsp_done;
   logic [3:0] credits;
   logic       starve;
   logic       credit_err;

   int checks = 0;
   int errors = 0;

   rbus_inject_sched #(.NREQ(4), .STARVE_MAX(15), .MAX_OUTST(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .gntA         (gntA),
      .gntB         (gntB),
      .rbus_rdyOutA (rbus_rdyOutA),
      .rbus_rdyOutB (rbus_rdyOutB),
      .rbus_rdyIn   (rbus_rdyIn),
      .rsp_done     (rsp_done),
      .credits      (credits),
      .starve       (starve),
      .credit_err   (credit_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; rbus_rdyIn = 1'b0; rsp_done = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (gntA !== 4'b0000) begin errors++; $display("FAIL reset_gntA got %b exp 0000", gntA); end
      checks++; if (gntB !== 4'b0000) begin errors++; $display("FAIL reset_gntB got %b exp 0000", gntB); end
      checks++; if (credits !== 4'd8) begin errors++; $display("FAIL reset_credits got %0d exp 8", credits); end
      checks++; if (starve !== 1'b0) begin errors++; $display("FAIL reset_starve got %b exp 0", starve); end
      checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL reset_credit_err got %b exp 0", credit_err); end
      req = 4'b0010;
      #1;
      checks++; if (gntA !== 4'b0010 || rbus_rdyOutA !== 1'b1) begin
         errors++; $display("FAIL reset_single_req gntA %b rdyA %b exp 0010 1", gntA, rbus_rdyOutA); end
      checks++; if (gntB !== 4'b0000 || rbus_rdyOutB !== 1'b0) begin
         errors++; $display("FAIL reset_single_portB gntB %b rdyB %b exp 0000 0", gntB, rbus_rdyOutB); end
   endtask

   // All four agents requesting with the ring ready until credits run out.
   task automatic test_round_robin();
      int ncyc;
      logic [3:0] exp_a, exp_b;
      int exp_c;
      do_reset();
      req = 4'b1111; rbus_rdyIn = 1'b1;
      ncyc = DUAL ? 5 : 9;
      for (int c = 0; c < ncyc; c++) begin
         if (c == ncyc - 1) begin
            exp_a = 4'b0000; exp_b = 4'b0000; exp_c = 0;
         end else if (DUAL) begin
            exp_a = 4'b0001 << ((2 * c) % 4);
            exp_b = 4'b0001 << ((2 * c + 1) % 4);
            exp_c = 8 - 2 * c;
         end else begin
            exp_a = 4'b0001 << (c % 4);
            exp_b = 4'b0000;
            exp_c = 8 - c;
         end
         #1;
         checks++; if (gntA !== exp_a) begin errors++; $display("FAIL rr_gntA cyc %0d got %b exp %b", c, gntA, exp_a); end
         checks++; if (gntB !== exp_b || rbus_rdyOutB !== (|exp_b)) begin
            errors++; $display("FAIL rr_gntB cyc %0d got %b/%b exp %b", c, gntB, rbus_rdyOutB, exp_b); end
         checks++; if (credits !== 4'(exp_c)) begin errors++; $display("FAIL rr_credits cyc %0d got %0d exp %0d", c, credits, exp_c); end
         tick();
      end
   endtask

   // Continues from zero credits left by the round-robin test.
   task automatic test_credit_one();
      req = 4'b0000; rbus_rdyIn = 1'b0; rsp_done = 1'b1;
      tick();
      #1;
      checks++; if (credits !== 4'd1) begin errors++; $display("FAIL c1_return got %0d exp 1", credits); end
      req = 4'b0011; rbus_rdyIn = 1'b1; rsp_done = 1'b1;
      #1;
      checks++; if (gntA !== 4'b0001 || rbus_rdyOutA !== 1'b1) begin
         errors++; $display("FAIL c1_gntA got %b/%b exp 0001/1", gntA, rbus_rdyOutA); end
      checks++; if (gntB !== 4'b0000 || rbus_rdyOutB !== 1'b0) begin
         errors++; $display("FAIL c1_gntB got %b/%b exp 0000/0", gntB, rbus_rdyOutB); end
      tick();
      rsp_done = 1'b0; req = 4'b0000; rbus_rdyIn = 1'b0;
      #1;
      checks++; if (credits !== 4'd1) begin errors++; $display("FAIL c1_simul got %0d exp 1", credits); end
   endtask

   task automatic test_starve();
      do_reset();
      req = 4'b0001; rbus_rdyIn = 1'b0;
      for (int i = 0; i < 14; i++) tick();
      #1;
      checks++; if (starve !== 1'b0) begin errors++; $display("FAIL starve_early got %b exp 0", starve); end
      tick();
      #1;
      checks++; if (starve !== 1'b1 || gntA !== 4'b0001) begin
         errors++; $display("FAIL starve_set starve %b gntA %b exp 1 0001", starve, gntA); end
      rbus_rdyIn = 1'b1;
      tick();
      #1;
      checks++; if (starve !== 1'b0 || credits !== 4'd7) begin
         errors++; $display("FAIL starve_release starve %b credits %0d exp 0 7", starve, credits); end
      req = 4'b0000; rbus_rdyIn = 1'b0;
   endtask

   task automatic test_drop_req();
      do_reset();
      req = 4'b0001; rbus_rdyIn = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      req = 4'b0000;
      #1;
      checks++; if (gntA !== 4'b0000 || rbus_rdyOutA !== 1'b0) begin
         errors++; $display("FAIL drop_gnt got %b/%b exp 0000/0", gntA, rbus_rdyOutA); end
      tick();
      req = 4'b0001;
      for (int i = 0; i < 14; i++) tick();
      #1;
      checks++; if (starve !== 1'b0) begin errors++; $display("FAIL drop_cleared got %b exp 0", starve); end
      tick();
      #1;
      checks++; if (starve !== 1'b1) begin errors++; $display("FAIL drop_reaged got %b exp 1", starve); end
   endtask

   // Agents 2 and 3 age together with ptr=3; the forced pick must lead with 2.
   task automatic test_aged_priority();
      do_reset();
      req = 4'b0100; rbus_rdyIn = 1'b1;
      #1;
      checks++; if (gntA !== 4'b0100) begin errors++; $display("FAIL aged_setup got %b exp 0100", gntA); end
      tick();
      req = 4'b1100; rbus_rdyIn = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      #1;
      checks++; if (starve !== 1'b1) begin errors++; $display("FAIL aged_starve got %b exp 1", starve); end
      checks++; if (gntA !== 4'b0100) begin errors++; $display("FAIL aged_gntA got %b exp 0100", gntA); end
      checks++; if (gntB !== (DUAL ? 4'b1000 : 4'b0000)) begin
         errors++; $display("FAIL aged_gntB got %b exp %b", gntB, DUAL ? 4'b1000 : 4'b0000); end
      rbus_rdyIn = 1'b1;
      tick();
      req = 4'b1111; rbus_rdyIn = 1'b0;
      #1;
      checks++; if (gntA !== (DUAL ? 4'b0001 : 4'b1000)) begin
         errors++; $display("FAIL aged_ptr_gntA got %b exp %b", gntA, DUAL ? 4'b0001 : 4'b1000); end
      checks++; if (gntB !== (DUAL ? 4'b0010 : 4'b0000)) begin
         errors++; $display("FAIL aged_ptr_gntB got %b exp %b", gntB, DUAL ? 4'b0010 : 4'b0000); end
      checks++; if (starve !== (DUAL ? 1'b0 : 1'b1)) begin
         errors++; $display("FAIL aged_exit got %b exp %b", starve, DUAL ? 1'b0 : 1'b1); end
      checks++; if (credits !== (DUAL ? 4'd5 : 4'd6)) begin
         errors++; $display("FAIL aged_credits got %0d exp %0d", credits, DUAL ? 5 : 6); end
   endtask

   task automatic test_credit_err();
      do_reset();
      rsp_done = 1'b1;
      #1;
      checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL err_comb got %b exp 0", credit_err); end
      tick();
      rsp_done = 1'b0;
      #1;
      checks++; if (credit_err !== 1'b1 || credits !== 4'd8) begin
         errors++; $display("FAIL err_set err %b credits %0d exp 1 8", credit_err, credits); end
      tick();
      #1;
      checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", credit_err); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL err_rst got %b exp 0", credit_err); end
   endtask

   initial begin
      rst = 1'b1; req = '0; rbus_rdyIn = 1'b0; rsp_done = 1'b0;
      test_reset();
      test_round_robin();
      test_credit_one();
      test_starve();
      test_drop_req();
      test_aged_priority();
      test_credit_err();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
